// File: rtl/booth_pkg.sv
// Shared types and ASCII helpers for the Booth multiplier result path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] nib2hex(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_0 + {4'h0, nib};
        else
            return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 single-byte serialiser, LSB first, CLKS_PER_BIT cycles per bit.
// Latency: line drops on the start edge; a frame is 10*CLKS_PER_BIT cycles.
// Backpressure: start is honoured only when idle or in the final stop-bit cycle (done high).
module uart_tx_byte
    import booth_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx_serial
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end = (clk_cnt == CNT_LAST);
    assign busy    = (state != IDLE);
    // High during the last cycle of the stop bit so a follow-on byte can start with no gap.
    assign done    = (state == STOP) && bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            tx_serial <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= 3'd0;
                    if (start) begin
                        state     <= START;
                        shreg     <= data;
                        tx_serial <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        bit_cnt   <= 3'd0;
                        state     <= DATA;
                        tx_serial <= shreg[0];
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state     <= STOP;
                            tx_serial <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            shreg     <= {1'b0, shreg[7:1]};
                            tx_serial <= shreg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (start) begin
                            state     <= START;
                            shreg     <= data;
                            tx_serial <= 1'b0;
                        end else begin
                            state     <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx_serial <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/booth_result_tx.sv
// Sends each new Booth product over UART as "HH\r\n" (or one raw byte).
// Latency: trigger to tx_done = 40*CLKS_PER_BIT (ASCII) or 10*CLKS_PER_BIT (raw).
// Backpressure: none upstream; a trigger while busy is dropped and flags sticky overrun.
module booth_result_tx
    import booth_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int ASCII_MODE   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] product_in,
    input  logic       product_dv,
    output logic       tx_serial,
    output logic       tx_active,
    output logic       tx_done,
    output logic       overrun
);

    logic       dv_q;
    logic [7:0] prod_q;
    logic [1:0] char_idx;
    logic       trig;
    logic       idle;
    logic       accept;
    logic       last_char;
    logic       byte_start;
    logic [7:0] byte_data;
    logic       byte_busy;
    logic       byte_done;

    function automatic logic [7:0] char_at(input logic [7:0] prod, input logic [1:0] idx);
        case (idx)
            2'd0:    return (ASCII_MODE != 0) ? nib2hex(prod[7:4]) : prod;
            2'd1:    return nib2hex(prod[3:0]);
            2'd2:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

    assign trig      = product_dv && !dv_q;
    assign idle      = !tx_active && !byte_busy;
    assign accept    = trig && idle;
    assign last_char = (ASCII_MODE == 0) || (char_idx == 2'd3);

    // The first character comes straight from product_in so the start bit begins on the trigger edge.
    assign byte_start = accept || (tx_active && byte_done && !last_char);
    assign byte_data  = accept ? char_at(product_in, 2'd0) : char_at(prod_q, char_idx + 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q      <= 1'b1;
            prod_q    <= 8'h00;
            char_idx  <= 2'd0;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            dv_q    <= product_dv;
            tx_done <= 1'b0;
            if (trig && !idle)
                overrun <= 1'b1;
            if (accept) begin
                prod_q    <= product_in;
                char_idx  <= 2'd0;
                tx_active <= 1'b1;
            end else if (tx_active && byte_done) begin
                if (last_char) begin
                    tx_active <= 1'b0;
                    char_idx  <= 2'd0;
                    tx_done   <= 1'b1;
                end else begin
                    char_idx <= char_idx + 2'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (byte_start),
        .data      (byte_data),
        .busy      (byte_busy),
        .done      (byte_done),
        .tx_serial (tx_serial)
    );

endmodule

// File: tb/tb_booth_result_tx.sv
// Bench for booth_result_tx: one ASCII-mode and one raw-mode instance, CLKS_PER_BIT=4.
// UART monitors decode each line and compare against per-instance expected-byte queues.
module tb_booth_result_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n_a, rst_n_r;
    logic [7:0] pin_a, pin_r;
    logic       dv_a, dv_r;
    logic       tx_a, act_a, done_a, ovr_a;
    logic       tx_r, act_r, done_r, ovr_r;
    logic       ign_a = 1'b0;
    wire  [1:0] line = {tx_r, tx_a};

    logic [7:0] exp_a[$];
    logic [7:0] exp_r[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_result_tx #(.CLKS_PER_BIT(CPB), .ASCII_MODE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .product_in(pin_a), .product_dv(dv_a),
        .tx_serial(tx_a), .tx_active(act_a), .tx_done(done_a), .overrun(ovr_a)
    );

    booth_result_tx #(.CLKS_PER_BIT(CPB), .ASCII_MODE(0)) u_dut_r (
        .clk(clk), .rst_n(rst_n_r), .product_in(pin_r), .product_dv(dv_r),
        .tx_serial(tx_r), .tx_active(act_r), .tx_done(done_r), .overrun(ovr_r)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Decode one UART line; sampling at cycle CPB/2 of each bit, on negedges.
    task automatic mon(input int k);
        logic [7:0] b;
        logic       frame_ok;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (line[k] == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                frame_ok = (line[k] == 1'b0);
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    b[j] = line[k];
                end
                repeat (CPB) @(negedge clk);
                frame_ok = frame_ok && (line[k] == 1'b1);
                if (!(k == 0 && ign_a)) begin
                    check($sformatf("mon%0d framing", k), {31'd0, frame_ok}, 32'd1);
                    if ((k == 0 && exp_a.size() == 0) || (k == 1 && exp_r.size() == 0)) begin
                        total++;
                        bad++;
                        $display("FAIL mon%0d unexpected frame actual=%02h required=none", k, b);
                    end else begin
                        e = (k == 0) ? exp_a.pop_front() : exp_r.pop_front();
                        check($sformatf("mon%0d byte", k), {24'd0, b}, {24'd0, e});
                    end
                end
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    initial begin
        int act_n, done_at, done_n, errs;
        logic [9:0] pat;

        // Reset with product_dv already high on both instances.
        rst_n_a = 1'b0; rst_n_r = 1'b0;
        pin_a = 8'h00; pin_r = 8'h00;
        dv_a = 1'b1; dv_r = 1'b1;
        repeat (3) @(negedge clk);
        check("rst tx_serial", {31'd0, tx_a}, 32'd1);
        check("rst tx_active", {31'd0, act_a}, 32'd0);
        check("rst tx_done", {31'd0, done_a}, 32'd0);
        check("rst overrun", {31'd0, ovr_a}, 32'd0);
        check("rst raw tx_serial", {31'd0, tx_r}, 32'd1);
        check("rst raw tx_active", {31'd0, act_r}, 32'd0);
        rst_n_a = 1'b1; rst_n_r = 1'b1;
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || act_a !== 1'b0 || tx_r !== 1'b1 || act_r !== 1'b0)
                errs++;
        end
        check("dv high at reset release no trigger", errs, 0);
        dv_a = 1'b0; dv_r = 1'b0;
        repeat (4) @(negedge clk);

        // Raw mode, 0x06: bits 0,0,1,1,0,0,0,0,0,1.
        pat = 10'b1000001100;
        exp_r.push_back(8'h06);
        pin_r = 8'h06; dv_r = 1'b1;
        @(posedge clk);
        errs = 0; done_at = -1; done_n = 0; act_n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 5) dv_r = 1'b0;
            if (i < 40 && tx_r !== pat[i / CPB]) errs++;
            if (act_r === 1'b1) act_n++;
            if (done_r === 1'b1) begin done_n++; done_at = i; end
        end
        check("raw bit pattern", errs, 0);
        check("raw tx_active cycles", act_n, 40);
        check("raw tx_done cycle", done_at, 40);
        check("raw tx_done pulses", done_n, 1);

        // Raw mode, negative product sent as two's-complement bits.
        exp_r.push_back(8'hF4);
        pin_r = 8'hF4; dv_r = 1'b1;
        repeat (5) @(negedge clk);
        dv_r = 1'b0;
        repeat (60) @(negedge clk);

        // ASCII mode, 0xF4 -> "F4\r\n".
        exp_a.push_back(8'h46); exp_a.push_back(8'h34);
        exp_a.push_back(8'h0D); exp_a.push_back(8'h0A);
        pin_a = 8'hF4; dv_a = 1'b1;
        @(posedge clk);
        done_at = -1; done_n = 0; act_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 10) dv_a = 1'b0;
            if (act_a === 1'b1) act_n++;
            if (done_a === 1'b1) begin done_n++; done_at = i; end
        end
        check("ascii tx_active cycles", act_n, 160);
        check("ascii tx_done cycle", done_at, 160);
        check("ascii tx_done pulses", done_n, 1);

        // Overrun: second rising edge mid-transmission is dropped.
        exp_a.push_back(8'h30); exp_a.push_back(8'h46);
        exp_a.push_back(8'h0D); exp_a.push_back(8'h0A);
        pin_a = 8'h0F; dv_a = 1'b1;
        @(posedge clk);
        done_at = -1; done_n = 0;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (i == 10) dv_a = 1'b0;
            if (i == 50) begin
                check("overrun before second edge", {31'd0, ovr_a}, 32'd0);
                pin_a = 8'h09; dv_a = 1'b1;
            end
            if (i == 51) check("overrun after second edge", {31'd0, ovr_a}, 32'd1);
            if (i == 60) dv_a = 1'b0;
            if (done_a === 1'b1) begin done_n++; done_at = i; end
        end
        check("overrun tx_done cycle", done_at, 160);
        check("overrun tx_done pulses", done_n, 1);
        check("overrun sticky", {31'd0, ovr_a}, 32'd1);

        // Reset at cycle 20 of a frame: line high at once, no done, overrun cleared.
        ign_a = 1'b1;
        pin_a = 8'h55; dv_a = 1'b1;
        @(posedge clk);
        errs = 0; done_n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 5) dv_a = 1'b0;
            if (i == 19) check("frame in progress", {31'd0, act_a}, 32'd1);
            if (i == 20) begin
                rst_n_a = 1'b0;
                #1;
                check("midreset tx_serial", {31'd0, tx_a}, 32'd1);
                check("midreset tx_active", {31'd0, act_a}, 32'd0);
                check("midreset overrun", {31'd0, ovr_a}, 32'd0);
            end
            if (i == 23) rst_n_a = 1'b1;
            if (i >= 20 && (tx_a !== 1'b1 || act_a !== 1'b0)) errs++;
            if (done_a === 1'b1) done_n++;
        end
        check("midreset line idle after", errs, 0);
        check("midreset no tx_done", done_n, 0);
        ign_a = 1'b0;

        // Back-to-back: 0x12 then 0x81 sampled on the tx_done cycle.
        exp_a.push_back(8'h31); exp_a.push_back(8'h32);
        exp_a.push_back(8'h0D); exp_a.push_back(8'h0A);
        exp_a.push_back(8'h38); exp_a.push_back(8'h31);
        exp_a.push_back(8'h0D); exp_a.push_back(8'h0A);
        pin_a = 8'h12; dv_a = 1'b1;
        @(posedge clk);
        done_at = -1; done_n = 0; act_n = 0;
        for (int i = 0; i < 360; i++) begin
            @(negedge clk);
            if (i == 10) dv_a = 1'b0;
            if (i == 160) begin
                check("b2b first tx_done", {31'd0, done_a}, 32'd1);
                pin_a = 8'h81; dv_a = 1'b1;
            end
            if (i == 170) dv_a = 1'b0;
            if (i < 321 && act_a === 1'b0) act_n++;
            if (done_a === 1'b1) begin done_n++; done_at = i; end
        end
        check("b2b idle cycles between", act_n, 1);
        check("b2b tx_done pulses", done_n, 2);
        check("b2b second tx_done cycle", done_at, 321);
        check("b2b overrun", {31'd0, ovr_a}, 32'd0);

        repeat (20) @(negedge clk);
        check("ascii queue drained", exp_a.size(), 0);
        check("raw queue drained", exp_r.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_result_tx.md
Name: booth_result_tx

Overview:
- Downstream stage of the Booth multiplier. Captures the 8-bit signed product on each new rising edge of the multiplier's data-valid output.
- Serialises the product over a UART 8N1 line using the shared CLKS_PER_BIT baud convention (5208 = 9600 baud at 50 MHz).
- Default output is human-readable: two uppercase ASCII hex characters followed by CR LF. A raw single-byte mode is also available.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per UART bit; legal range ≥ 2.
- ASCII_MODE, 1: 1 = send hex-hi, hex-lo, 0x0D, 0x0A (4 frames); 0 = send the raw product byte (1 frame).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- product_in  in  8  product from the multiplier; sampled only on trigger.
- product_dv  in  1  multiplier done level; a 0→1 transition is the trigger.
- tx_serial  out  1  UART line; idles high.
- tx_active  out  1  high from the first start bit to the end of the last stop bit.
- tx_done  out  1  one-cycle pulse after the last stop bit completes.
- overrun  out  1  sticky; set when a trigger arrives while busy; cleared only by reset.

Behaviour:
- Reset, asynchronous on rst_n low:
  - tx_serial=1, tx_active=0, tx_done=0, overrun=0.
  - State=IDLE; bit counter, clock counter and char index = 0.
  - dv_q (registered product_dv) = 1, so a product_dv already high at reset release does not trigger.
- Trigger: sampled product_dv=1 and dv_q=0 while in IDLE.
  - On that clock edge, latch product_in into prod_q.
  - Enter START with char index 0; tx_serial=0 and tx_active=1 from that edge.
- Trigger while not IDLE: set overrun=1. The current transmission is unaffected and the new product is dropped.
- FSM states: IDLE → START → DATA → STOP → (next char ? START : IDLE).
  - Each state, and each of the 8 DATA bits, holds tx_serial for exactly CLKS_PER_BIT cycles.
  - The clock counter counts 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide.
- DATA sends LSB first; STOP drives tx_serial=1.
- No idle gap between characters: the next start bit begins on the edge after the previous stop bit's final cycle.
- Frame = 10·CLKS_PER_BIT cycles. Trigger-to-tx_done latency:
  - ASCII_MODE=1: 40·CLKS_PER_BIT.
  - ASCII_MODE=0: 10·CLKS_PER_BIT.
- Character encoding:
  - Nibble n in 0..9 → 0x30+n; n in 10..15 → 0x41+(n-10), uppercase.
  - ASCII order: prod_q[7:4], prod_q[3:0], 0x0D, 0x0A.
- End of transmission: on the edge ending the last stop bit, state=IDLE, tx_active=0, tx_done=1 for exactly one cycle.
- Back-to-back: a trigger sampled on the cycle tx_done is high is accepted normally, because state is already IDLE.
- Signedness: the product is transmitted as raw two's-complement bits (0xF4, not "-0C").
- Reset mid-frame: the line returns high immediately and the frame is abandoned. No tx_done pulse; overrun is cleared.

Decomposition:
- Shared package booth_pkg holds:
  - state enum {IDLE, START, DATA, STOP};
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A=8'h41;
  - function nib2hex(4-bit) → 8-bit.
- Natural sub-module: uart_tx_byte (CLKS_PER_BIT; ports clk, rst_n, start, data[7:0], busy, done, tx_serial).
  - It owns START/DATA/STOP timing.
  - booth_result_tx owns edge detection, product latch, character sequencing and overrun.

Test Plan (CLKS_PER_BIT=4):
- ASCII_MODE=1, product_in=0xF4 (3×−4), product_dv 0→1:
  - line carries frames 0x46, 0x34, 0x0D, 0x0A, LSB first, each with a start and stop bit;
  - tx_active high for 160 cycles; tx_done pulses at cycle 160.
- ASCII_MODE=0, product_in=0x06, trigger:
  - single frame with bits 0,0,1,1,0,0,0,0,0,1, each held 4 cycles;
  - tx_done at cycle 40.
- Overrun: trigger with 0x0F, then a second product_dv rising edge at cycle 50 with 0x09:
  - overrun=1 from cycle 51;
  - line still carries "0F\r\n" only; no further frame follows.
- Reset handling:
  - product_dv held high through rst_n deassert → tx_serial stays 1 and tx_active stays 0 for 200 cycles.
  - rst_n asserted at cycle 20 of a frame → tx_serial=1 asynchronously; no tx_done pulse.
- Back-to-back: second trigger (0x81) sampled on the tx_done cycle of the first (0x12):
  - "12\r\n81\r\n" is sent with a single idle cycle between the two transmissions;
  - overrun stays 0.
